// File: rtl/float_pkg.sv
// Shared types and helpers for the sequential float multiplier.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package float_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        ROUND,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } op_class_t;

    localparam logic RM_TRUNC = 1'b0;
    localparam logic RM_RNE   = 1'b1;

    // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
    // Returned wide; callers cast down to their own float width.
    function automatic logic [127:0] canonical_qnan(input int exp_size, input int man_size);
        logic [127:0] q;
        q = ((128'd1 << exp_size) - 128'd1) << man_size;
        q = q | (128'd1 << (man_size - 1));
        return q;
    endfunction

endpackage

// File: rtl/float_classify.sv
// Maps the magnitude bits of a float (sign excluded) to its operand class.
// Latency: combinational.
// Backpressure: n/a.
// Ports: mag = {exponent, mantissa}; op_class = ZERO (exp 0, subnormals flushed),
//        INF, NAN or NORMAL.
module float_classify
    import float_pkg::*;
#(
    parameter int EXPONENT_SIZE = 8,
    parameter int MANTISSA_SIZE = 23
) (
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE-1:0] mag,
    output op_class_t                              op_class
);

    logic [EXPONENT_SIZE-1:0] exp_field;
    logic [MANTISSA_SIZE-1:0] man_field;

    assign exp_field = mag[EXPONENT_SIZE+MANTISSA_SIZE-1:MANTISSA_SIZE];
    assign man_field = mag[MANTISSA_SIZE-1:0];

    always_comb begin
        op_class = NORMAL;
        if (exp_field == '0) begin
            op_class = ZERO;
        end else if (&exp_field) begin
            op_class = (man_field == '0) ? INF : NAN;
        end
    end

endmodule

// File: rtl/float_multiplier_seq.sv
// Iterative float multiplier: shift-add significand product, one bit per cycle, then normalise/round.
// Latency: special operands 1 cycle after accept; normal operands MANTISSA_SIZE+3 edges counting the accept edge.
// Backpressure: one transaction in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: in_valid/in_ready/a/b/round_mode upstream; out_valid/out_ready/out + overflow,
//        underflow, inexact, invalid downstream (flags valid only while out_valid).
module float_multiplier_seq
    import float_pkg::*;
#(
    parameter int FLOAT_SIZE    = 32,
    parameter int EXPONENT_SIZE = 8,
    parameter int MANTISSA_SIZE = 23,
    parameter int BIAS          = 127
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FLOAT_SIZE-1:0] a,
    input  logic [FLOAT_SIZE-1:0] b,
    input  logic                  round_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FLOAT_SIZE-1:0] out,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  inexact,
    output logic                  invalid
);

    localparam int PW = 2 * (MANTISSA_SIZE + 1);   // full significand product width
    localparam int EW = EXPONENT_SIZE + 2;         // signed working exponent width
    localparam int CW = $clog2(MANTISSA_SIZE + 1);

    localparam logic [CW-1:0]            CNT_LAST   = CW'(MANTISSA_SIZE);
    localparam logic [FLOAT_SIZE-1:0]    QNAN       = FLOAT_SIZE'(canonical_qnan(EXPONENT_SIZE, MANTISSA_SIZE));
    localparam logic [EXPONENT_SIZE-1:0] EXP_ONES   = '1;
    localparam logic [EXPONENT_SIZE-1:0] EXP_MAXFIN = {{(EXPONENT_SIZE-1){1'b1}}, 1'b0};
    localparam logic signed [EW-1:0]     EXP_OVF    = EW'((1 << EXPONENT_SIZE) - 1);
    localparam logic signed [EW-1:0]     EXP_ZERO   = '0;

    state_t                   state;
    logic [CW-1:0]            cnt_q;
    logic                     sign_q;
    logic                     rm_q;
    logic [EXPONENT_SIZE-1:0] ea_q, eb_q;
    logic [PW-1:0]            acc_q, mcand_q;
    logic [MANTISSA_SIZE:0]   mplier_q;

    op_class_t a_class, b_class;

    float_classify #(.EXPONENT_SIZE(EXPONENT_SIZE), .MANTISSA_SIZE(MANTISSA_SIZE)) u_class_a (
        .mag      (a[FLOAT_SIZE-2:0]),
        .op_class (a_class)
    );

    float_classify #(.EXPONENT_SIZE(EXPONENT_SIZE), .MANTISSA_SIZE(MANTISSA_SIZE)) u_class_b (
        .mag      (b[FLOAT_SIZE-2:0]),
        .op_class (b_class)
    );

    assign in_ready = (state == IDLE);

    // Special-operand result, evaluated on the raw inputs at accept time.
    logic                  prod_sign;
    logic                  spec_hit;
    logic                  spec_invalid;
    logic [FLOAT_SIZE-1:0] spec_out;

    assign prod_sign = a[FLOAT_SIZE-1] ^ b[FLOAT_SIZE-1];

    always_comb begin
        spec_hit     = 1'b1;
        spec_invalid = 1'b0;
        spec_out     = '0;
        if (a_class == NAN || b_class == NAN ||
            (a_class == INF && b_class == ZERO) || (a_class == ZERO && b_class == INF)) begin
            spec_out     = QNAN;
            spec_invalid = 1'b1;
        end else if (a_class == INF || b_class == INF) begin
            spec_out = {prod_sign, EXP_ONES, {MANTISSA_SIZE{1'b0}}};
        end else if (a_class == ZERO || b_class == ZERO) begin
            spec_out = {prod_sign, {(FLOAT_SIZE-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Normalise, round and range-check the finished product.
    logic                     norm_shift;
    logic [MANTISSA_SIZE-1:0] mant;
    logic                     guard, sticky, rnd_inc;
    logic [MANTISSA_SIZE:0]   mant_inc;
    logic signed [EW-1:0]     e_pre, e_fin;
    logic [FLOAT_SIZE-1:0]    rnd_out;
    logic                     rnd_ovf, rnd_unf, rnd_inexact;

    always_comb begin
        norm_shift = acc_q[PW-1];
        if (norm_shift) begin
            mant   = acc_q[PW-2 -: MANTISSA_SIZE];
            guard  = acc_q[MANTISSA_SIZE];
            sticky = |acc_q[MANTISSA_SIZE-1:0];
        end else begin
            mant   = acc_q[PW-3 -: MANTISSA_SIZE];
            guard  = acc_q[MANTISSA_SIZE-1];
            sticky = |acc_q[MANTISSA_SIZE-2:0];
        end
        rnd_inc  = (rm_q == RM_RNE) & guard & (sticky | mant[0]);
        // A carry out of the mantissa leaves the field at zero and bumps the exponent.
        mant_inc = {1'b0, mant} + {{MANTISSA_SIZE{1'b0}}, rnd_inc};
        e_pre    = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - $signed(EW'(BIAS))
                 + $signed({{(EW-1){1'b0}}, norm_shift});
        e_fin    = e_pre + $signed({{(EW-1){1'b0}}, mant_inc[MANTISSA_SIZE]});

        rnd_ovf     = 1'b0;
        rnd_unf     = 1'b0;
        rnd_inexact = guard | sticky;
        rnd_out     = {sign_q, e_fin[EXPONENT_SIZE-1:0], mant_inc[MANTISSA_SIZE-1:0]};
        if (e_fin >= EXP_OVF) begin
            rnd_ovf     = 1'b1;
            rnd_inexact = 1'b1;
            rnd_out     = (rm_q == RM_RNE) ? {sign_q, EXP_ONES, {MANTISSA_SIZE{1'b0}}}
                                           : {sign_q, EXP_MAXFIN, {MANTISSA_SIZE{1'b1}}};
        end else if (e_fin <= EXP_ZERO) begin
            rnd_unf     = 1'b1;
            rnd_inexact = 1'b1;
            rnd_out     = {sign_q, {(FLOAT_SIZE-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            rm_q      <= RM_TRUNC;
            ea_q      <= '0;
            eb_q      <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= prod_sign;
                        rm_q     <= round_mode;
                        ea_q     <= a[FLOAT_SIZE-2:MANTISSA_SIZE];
                        eb_q     <= b[FLOAT_SIZE-2:MANTISSA_SIZE];
                        acc_q    <= '0;
                        mcand_q  <= {{(PW-MANTISSA_SIZE-1){1'b0}}, 1'b1, a[MANTISSA_SIZE-1:0]};
                        mplier_q <= {1'b1, b[MANTISSA_SIZE-1:0]};
                        cnt_q    <= '0;
                        if (spec_hit) begin
                            out       <= spec_out;
                            invalid   <= spec_invalid;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= MULT;
                        end
                    end
                end
                MULT: begin
                    acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    out       <= rnd_out;
                    overflow  <= rnd_ovf;
                    underflow <= rnd_unf;
                    inexact   <= rnd_inexact;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        inexact   <= 1'b0;
                        invalid   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
